ps2_keymap_decoder: RTL

Stateful PS/2 Set-2 scancode-to-ASCII decoder for the keyboard input path. It sits between the PS/2 byte receiver and the character consumer (game/terminal logic). It tracks make/break and extended prefixes, Shift and Caps Lock state, and case. Translated characters are buffered in a parametrised first-word-fall-through FIFO with a valid/ready output handshake.

---
 rtl/ps2_keymap_decoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keymap_decoder.sv
// PS/2 Set-2 scancode to ASCII decoder with Shift/Caps tracking and an output FIFO.
// Latency: a mapped make code is written on the edge that samples it; visible on ascii_out one cycle later if the FIFO was empty.
// Backpressure: first-word-fall-through valid/ready output; a push into a full FIFO without a pop is dropped and sets sticky overflow.
module ps2_keymap_decoder #(
  parameter int FIFO_DEPTH   = 8,
  parameter bit LOWERCASE_EN = 1'b1,
  parameter bit DIGITS_EN    = 1'b1
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [7:0]                    code_in,
  input  logic                          code_valid,
  output logic [7:0]                    ascii_out,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic                          shift_state,
  output logic                          caps_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [7:0] C_BREAK  = 8'hF0;
  localparam logic [7:0] C_EXT    = 8'hE0;
  localparam logic [7:0] C_SHIFTL = 8'h12;
  localparam logic [7:0] C_SHIFTR = 8'h59;
  localparam logic [7:0] C_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic           r_shift_l;
  logic           r_shift_r;
  logic           r_caps;
  logic           r_caps_held;
  logic           r_overflow;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic           w_make;
  logic           w_break;
  logic [7:0]     w_letter;
  logic [7:0]     w_sym;
  logic [7:0]     w_char;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_push_ok;

  // Prefix state register; a reset discards any half-received prefix.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prefix next-state and classification of the current byte as make or break.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    if (code_valid) begin
      case (r_state)
        S_IDLE: begin
          if (code_in == C_BREAK) begin
            w_state_nxt = S_BREAK;
          end else if (code_in == C_EXT) begin
            w_state_nxt = S_EXT;
          end else begin
            w_make = 1'b1;
          end
        end
        S_BREAK: begin
          w_break     = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_EXT: begin
          w_state_nxt = (code_in == C_BREAK) ? S_EXT_BREAK : S_IDLE;
        end
        S_EXT_BREAK: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Scancode lookup; case uses the modifier registers as they were before this byte.
  always_comb begin
    w_letter = 8'h00;
    w_sym    = 8'h00;
    case (code_in)
      8'h1C: w_letter = 8'h41;
      8'h32: w_letter = 8'h42;
      8'h21: w_letter = 8'h43;
      8'h23: w_letter = 8'h44;
      8'h24: w_letter = 8'h45;
      8'h2B: w_letter = 8'h46;
      8'h34: w_letter = 8'h47;
      8'h33: w_letter = 8'h48;
      8'h43: w_letter = 8'h49;
      8'h3B: w_letter = 8'h4A;
      8'h42: w_letter = 8'h4B;
      8'h4B: w_letter = 8'h4C;
      8'h3A: w_letter = 8'h4D;
      8'h31: w_letter = 8'h4E;
      8'h44: w_letter = 8'h4F;
      8'h4D: w_letter = 8'h50;
      8'h15: w_letter = 8'h51;
      8'h2D: w_letter = 8'h52;
      8'h1B: w_letter = 8'h53;
      8'h2C: w_letter = 8'h54;
      8'h3C: w_letter = 8'h55;
      8'h2A: w_letter = 8'h56;
      8'h1D: w_letter = 8'h57;
      8'h22: w_letter = 8'h58;
      8'h35: w_letter = 8'h59;
      8'h1A: w_letter = 8'h5A;
      8'h29: w_sym    = 8'h20;
      8'h45: w_sym    = DIGITS_EN ? 8'h30 : 8'h00;
      8'h16: w_sym    = DIGITS_EN ? 8'h31 : 8'h00;
      8'h1E: w_sym    = DIGITS_EN ? 8'h32 : 8'h00;
      8'h26: w_sym    = DIGITS_EN ? 8'h33 : 8'h00;
      8'h25: w_sym    = DIGITS_EN ? 8'h34 : 8'h00;
      8'h2E: w_sym    = DIGITS_EN ? 8'h35 : 8'h00;
      8'h36: w_sym    = DIGITS_EN ? 8'h36 : 8'h00;
      8'h3D: w_sym    = DIGITS_EN ? 8'h37 : 8'h00;
      8'h3E: w_sym    = DIGITS_EN ? 8'h38 : 8'h00;
      8'h46: w_sym    = DIGITS_EN ? 8'h39 : 8'h00;
      8'h5A: w_sym    = DIGITS_EN ? 8'h0D : 8'h00;
      8'h66: w_sym    = DIGITS_EN ? 8'h08 : 8'h00;
      default: begin
        w_letter = 8'h00;
        w_sym    = 8'h00;
      end
    endcase
    if (w_letter != 8'h00) begin
      w_char = (LOWERCASE_EN && !(shift_state ^ r_caps)) ? (w_letter + 8'h20) : w_letter;
    end else begin
      w_char = w_sym;
    end
  end

  // Shift and Caps Lock tracking; Caps toggles once per physical press, ignoring typematic repeats.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (w_make) begin
      if (code_in == C_SHIFTL) r_shift_l <= 1'b1;
      if (code_in == C_SHIFTR) r_shift_r <= 1'b1;
      if (code_in == C_CAPS && !r_caps_held) begin
        r_caps      <= ~r_caps;
        r_caps_held <= 1'b1;
      end
    end else if (w_break) begin
      if (code_in == C_SHIFTL) r_shift_l   <= 1'b0;
      if (code_in == C_SHIFTR) r_shift_r   <= 1'b0;
      if (code_in == C_CAPS)   r_caps_held <= 1'b0;
    end
  end

  assign w_push    = w_make && (w_char != 8'h00);
  assign w_pop     = ascii_valid && ascii_ready;
  assign w_full    = (r_count == DEPTH_C);
  assign w_push_ok = w_push && (!w_full || w_pop);

  // FIFO pointers, occupancy and sticky overflow; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  // Character storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_char;
  end

  assign shift_state = r_shift_l | r_shift_r;
  assign caps_state  = r_caps;
  assign ascii_valid = (r_count != '0);
  assign ascii_out   = ascii_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;

endmodule
